// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Segment encoding is active-low: bit7 = dp, bits6..0 = g..a.
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Dividers derived from the default rates; instances recompute them from their own parameters.
  localparam int unsigned SCAN_DIV  = 100_000_000 / 1_000;
  localparam int unsigned BLINK_DIV = 1_000 / (2 * 2);

  function automatic int unsigned scan_div(input int unsigned clk_hz, input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic int unsigned blink_div(input int unsigned scan_hz, input int unsigned blink_hz);
    return scan_hz / (2 * blink_hz);
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] value);
    logic [7:0] seg;
    case (value)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running divider: tick is high for one cycle every DIV clocks (count 0..DIV-1).
module fnd_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND driver: double-buffered BCD digits, per-digit dp/blink,
// leading-zero blanking and a frame pulse on scan wrap.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1_000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   i_digits,
  input  logic [NUM_DIGITS-1:0]     i_dp_mask,
  input  logic [NUM_DIGITS-1:0]     i_blink_mask,
  input  logic                      i_lz_en,
  input  logic                      i_load,
  output logic [7:0]                fnd_data,
  output logic [NUM_DIGITS-1:0]     fnd_com,
  output logic                      o_frame
);

  localparam int unsigned TICK_DIV  = scan_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned PHASE_DIV = blink_div(SCAN_HZ, BLINK_HZ);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = (PHASE_DIV > 2) ? $clog2(PHASE_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(PHASE_DIV - 1);

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;

  logic                    tick;
  logic [IW-1:0]           idx, idx_nxt;
  logic [BW-1:0]           bcnt, bcnt_nxt;
  logic                    ph, ph_nxt;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    run_zero;
  logic [3:0]              value;
  logic [7:0]              data_nxt;
  logic [NUM_DIGITS-1:0]   com_nxt;

  fnd_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Walk from the top digit down; a digit stays blankable while everything above it is zero.
  always_comb begin
    run_zero = sh_lz;
    lz_blank = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      run_zero = run_zero && (sh_digits[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      lz_blank[NUM_DIGITS-1-i] = run_zero;
    end
    lz_blank[0] = 1'b0;
  end

  // Outputs are decoded for the index and blink phase that take effect on this tick.
  always_comb begin
    idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    if (bcnt == BLK_LAST) begin
      bcnt_nxt = '0;
      ph_nxt   = ~ph;
    end else begin
      bcnt_nxt = bcnt + BW'(1);
      ph_nxt   = ph;
    end
    value    = sh_digits[{idx_nxt, 2'b00} +: 4];
    data_nxt = lz_blank[idx_nxt] ? SEG_BLANK : seg_decode(value);
    if (sh_dp[idx_nxt]) data_nxt[7] = 1'b0;
    if (ph_nxt && sh_blink[idx_nxt]) data_nxt = SEG_BLANK;
    com_nxt = '1;
    com_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
      idx       <= '0;
      bcnt      <= '0;
      ph        <= 1'b0;
      fnd_data  <= SEG_BLANK;
      fnd_com   <= '1;
    end else begin
      if (i_load) begin
        sh_digits <= i_digits;
        sh_dp     <= i_dp_mask;
        sh_blink  <= i_blink_mask;
        sh_lz     <= i_lz_en;
      end
      if (tick) begin
        idx      <= idx_nxt;
        bcnt     <= bcnt_nxt;
        ph       <= ph_nxt;
        fnd_data <= data_nxt;
        fnd_com  <= com_nxt;
      end
    end
  end

  assign o_frame = tick && (idx == IDX_LAST);

endmodule
